cmd_timing_gate: RTL
====================

# cmd_timing_gate

Single-entry command holding stage that sits directly downstream of the per-bank tP counters. It accepts one DRAM command at a time from the main controller FSM and checks it against two sets of limits: the per-bank counters (tRCD/tRTP/tWR/tRP/tRAS), and the cross-bank limits it tracks itself (tRRD, tFAW, tCCD, tWTR). It releases the command to the PHY command bus as a one-cycle registered pulse as soon as every limit is met.

## Interface
- BANKS, 8, number of banks
- BA_BITS, 3, bank address width
- CYCLE_TRRD, 4, minimum ACT-to-ACT spacing (any banks), cycles
- CYCLE_TFAW, 20, rolling window that may hold at most 4 ACTs, cycles
- CYCLE_TCCD, 4, minimum RD/WR-to-RD/WR spacing, cycles
- CYCLE_TWTR, 10, minimum WR-to-RD spacing, measured from WR issue, cycles
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  holding register can take a command this cycle
- cmd_type  input  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF; 6–7 reserved
- cmd_bank  input  BA_BITS  target bank
- tp_ba_counter  input  BANKS*5  per-bank tP counter; bank b occupies [5b+4:5b]
- tras_counter  input  BANKS*6  per-bank tRAS counter; bank b occupies [6b+5:6b]
- issue_valid  output  1  one-cycle command pulse to the PHY
- issue_type  output  3  issued command type
- issue_bank  output  BA_BITS  issued bank
- stall_cause  output  3  0 none/empty, 1 tP, 2 tRAS, 3 tRRD, 4 tFAW, 5 tCCD, 6 tWTR

## Operation
- **Holding register.** One entry: hold_full, hold_type, hold_bank.
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = !hold_full || legal.
- **Legal.** legal is computed combinationally from the held entry and the current counters. It is true only when all of the following hold:
  - ACT: tp[hold_bank]==0, trrd_cnt==0, and at least one FAW slot ==0.
  - RD: tp[hold_bank]==0, tccd_cnt==0, twtr_cnt==0.
  - WR: tp[hold_bank]==0, tccd_cnt==0.
  - PRE: tp[hold_bank]==0 and tras[hold_bank]==0.
  - REF: tp==0 for every bank and tras==0 for every bank.
- **Issue.** When hold_full && legal, the next edge:
  - loads issue_type/issue_bank from the held entry;
  - sets issue_valid=1;
  - clears hold_full, unless a new command is accepted on that same edge, in which case that command is loaded.
  - issue_valid drops the following edge unless another issue occurs.
- **Discarded types.** cmd_type 0, 6 and 7 are accepted (cmd_ready obeys the same rule) and dropped. They never set hold_full.
- **Counters.** All are down-counters that saturate at 0. Each is loaded on the issue edge:
  - ACT: trrd_cnt ← CYCLE_TRRD-1; the lowest-index FAW slot at 0 ← CYCLE_TFAW-1.
  - RD or WR: tccd_cnt ← CYCLE_TCCD-1.
  - WR: twtr_cnt ← CYCLE_TWTR-1.
  - Counters not loaded decrement that edge.
- **FAW slots.** Four slot counters, each 5 bits wide minimum.
- **stall_cause.** Combinational. 0 when the register is empty or legal. Otherwise the lowest-numbered failing condition, in order tP, tRAS, tRRD, tFAW, tCCD, tWTR.

## Timing
- **Reset (asserted at any time, including mid-hold):** hold_full=0; all counters=0; issue_valid=0, issue_type=0, issue_bank=0; stall_cause=0; cmd_ready=1 immediately after release. A held command is lost.
- **Latency:** command accepted at edge E with all limits met → issue_valid high during the cycle after edge E+1. Minimum latency is 2 edges.
- **Throughput:** one command per cycle when every command is legal on arrival. Accept and issue on the same edge are allowed.
- **Spacing:** with a counter limit of N, two commands bound by it issue exactly N edges apart. N=1 imposes no extra delay.
- **Counter inputs:** tp_ba_counter and tras_counter are sampled combinationally in the evaluation cycle. A change visible in cycle k affects legal in cycle k only.
- **Stalled entry:** a held command waits indefinitely. cmd_ready stays 0 while hold_full && !legal, and cmd_bank/cmd_type are ignored.
- **Fifth ACT:** with all four FAW slots nonzero, an ACT stalls with stall_cause=4 until the oldest slot reaches 0.

## Test plan
- **Reset:** rst pulse while an ACT is held with tp=3 → issue_valid stays 0 after release, cmd_ready=1, stall_cause=0.
- **tRCD gate:** ACT to bank 2 with all counters 0 accepted at edge 0 → issue_valid at cycle after edge 1. Then RD to bank 2 with tp[2] driven 3,2,1,0 → stall_cause=1 until tp[2]=0, then issue on the next edge.
- **tRRD spacing:** back-to-back ACTs to banks 0 and 1 with CYCLE_TRRD=4 → issue edges exactly 4 apart; stall_cause=3 in between.
- **tFAW:** five ACTs to banks 0–4, CYCLE_TRRD=1, CYCLE_TFAW=20 → first four issue on consecutive edges. The fifth issues 20 edges after the first, with stall_cause=4 while waiting.
- **tWTR and tCCD:** WR bank 0 then RD bank 1 with CYCLE_TCCD=4, CYCLE_TWTR=10 → RD issues 10 edges after WR; stall_cause=5 for the first 3 waiting cycles, then 6.
- **tRAS/REF:** PRE to bank 5 with tras[5]=2 → stall_cause=2 for 2 cycles, then issue. REF with tp[7]=1 → one stall cycle (stall_cause=1), then issue.

Source files
------------

// File: rtl/cmd_timing_gate.sv
// cmd_timing_gate
//
// Single-entry command holding stage placed after the per-bank tP counters.
// It accepts one DRAM command at a time. It checks the held command against
// the per-bank counters (tRCD/tRTP/tWR/tRP/tRAS) and against the cross-bank
// limits tracked here (tRRD, tFAW, tCCD, tWTR). It releases the command as a
// one-cycle registered pulse on the first edge at which every limit is met.
//
// Handshake: a command transfers on any rising edge where
// cmd_valid && cmd_ready. cmd_ready is high when the holding register is
// empty, or when the held command issues on that same edge. While a held
// command is stalled, cmd_ready is low and cmd_type/cmd_bank are ignored.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cmd_valid       command request from the controller FSM
//   cmd_ready       holding register can take a command this cycle
//   cmd_type        0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6-7 reserved
//   cmd_bank        target bank
//   tp_ba_counter   per-bank tP counter, bank b at [5b+4:5b]
//   tras_counter    per-bank tRAS counter, bank b at [6b+5:6b]
//   issue_valid     one-cycle command pulse to the PHY
//   issue_type      issued command type
//   issue_bank      issued bank
//   stall_cause     0 none, 1 tP, 2 tRAS, 3 tRRD, 4 tFAW, 5 tCCD, 6 tWTR
module cmd_timing_gate #(
    parameter int BANKS      = 8,
    parameter int BA_BITS    = 3,
    parameter int CYCLE_TRRD = 4,
    parameter int CYCLE_TFAW = 20,
    parameter int CYCLE_TCCD = 4,
    parameter int CYCLE_TWTR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_type,
    input  logic [BA_BITS-1:0]   cmd_bank,
    input  logic [BANKS*5-1:0]   tp_ba_counter,
    input  logic [BANKS*6-1:0]   tras_counter,
    output logic                 issue_valid,
    output logic [2:0]           issue_type,
    output logic [BA_BITS-1:0]   issue_bank,
    output logic [2:0]           stall_cause
);

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam logic [2:0] ST_NONE = 3'd0;
    localparam logic [2:0] ST_TP   = 3'd1;
    localparam logic [2:0] ST_TRAS = 3'd2;
    localparam logic [2:0] ST_TRRD = 3'd3;
    localparam logic [2:0] ST_TFAW = 3'd4;
    localparam logic [2:0] ST_TCCD = 3'd5;
    localparam logic [2:0] ST_TWTR = 3'd6;

    // One width for every cross-bank counter; wide enough for limits up to 256.
    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] LOAD_TRRD = CNT_W'(CYCLE_TRRD - 1);
    localparam logic [CNT_W-1:0] LOAD_TFAW = CNT_W'(CYCLE_TFAW - 1);
    localparam logic [CNT_W-1:0] LOAD_TCCD = CNT_W'(CYCLE_TCCD - 1);
    localparam logic [CNT_W-1:0] LOAD_TWTR = CNT_W'(CYCLE_TWTR - 1);

    // Holding register
    logic               hold_full_q, hold_full_d;
    logic [2:0]         hold_type_q, hold_type_d;
    logic [BA_BITS-1:0] hold_bank_q, hold_bank_d;

    // Issue register
    logic               issue_valid_q, issue_valid_d;
    logic [2:0]         issue_type_q, issue_type_d;
    logic [BA_BITS-1:0] issue_bank_q, issue_bank_d;

    // Cross-bank limit counters
    logic [CNT_W-1:0] trrd_cnt_q, trrd_cnt_d;
    logic [CNT_W-1:0] tccd_cnt_q, tccd_cnt_d;
    logic [CNT_W-1:0] twtr_cnt_q, twtr_cnt_d;
    logic [CNT_W-1:0] faw_q [4];
    logic [CNT_W-1:0] faw_d [4];

    // Per-bank counter views
    logic [4:0] tp_arr   [BANKS];
    logic [5:0] tras_arr [BANKS];

    for (genvar g = 0; g < BANKS; g++) begin : g_unpack
        assign tp_arr[g]   = tp_ba_counter[g*5 +: 5];
        assign tras_arr[g] = tras_counter[g*6 +: 6];
    end

    logic       faw_free;
    logic [1:0] faw_idx;
    logic       fail_tp, fail_tras, fail_trrd, fail_faw, fail_tccd, fail_twtr;
    logic       legal;
    logic       issue;
    logic       accept;
    logic       keep_type;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // Lowest-index idle FAW slot. An ACT may only issue when one exists.
    always_comb begin
        faw_free = 1'b0;
        faw_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (faw_q[i] == '0) begin
                faw_free = 1'b1;
                faw_idx  = 2'(i);
            end
        end
    end

    // Limit checks for the held entry
    always_comb begin
        fail_tp   = 1'b0;
        fail_tras = 1'b0;
        fail_trrd = 1'b0;
        fail_faw  = 1'b0;
        fail_tccd = 1'b0;
        fail_twtr = 1'b0;
        case (hold_type_q)
            CMD_ACT: begin
                fail_tp   = (tp_arr[hold_bank_q] != '0);
                fail_trrd = (trrd_cnt_q != '0);
                fail_faw  = !faw_free;
            end
            CMD_RD: begin
                fail_tp   = (tp_arr[hold_bank_q] != '0);
                fail_tccd = (tccd_cnt_q != '0);
                fail_twtr = (twtr_cnt_q != '0);
            end
            CMD_WR: begin
                fail_tp   = (tp_arr[hold_bank_q] != '0);
                fail_tccd = (tccd_cnt_q != '0);
            end
            CMD_PRE: begin
                fail_tp   = (tp_arr[hold_bank_q] != '0);
                fail_tras = (tras_arr[hold_bank_q] != '0);
            end
            CMD_REF: begin
                // Refresh needs every bank quiet.
                fail_tp   = (tp_ba_counter != '0);
                fail_tras = (tras_counter != '0);
            end
            default: ;
        endcase
    end

    assign legal = hold_full_q &&
                   !(fail_tp || fail_tras || fail_trrd || fail_faw || fail_tccd || fail_twtr);
    assign issue     = legal;
    assign cmd_ready = !hold_full_q || legal;
    assign accept    = cmd_valid && cmd_ready;
    assign keep_type = (cmd_type >= CMD_ACT) && (cmd_type <= CMD_REF);

    // Report the first failing limit in fixed priority order.
    always_comb begin
        stall_cause = ST_NONE;
        if (hold_full_q && !legal) begin
            if (fail_tp)        stall_cause = ST_TP;
            else if (fail_tras) stall_cause = ST_TRAS;
            else if (fail_trrd) stall_cause = ST_TRRD;
            else if (fail_faw)  stall_cause = ST_TFAW;
            else if (fail_tccd) stall_cause = ST_TCCD;
            else if (fail_twtr) stall_cause = ST_TWTR;
        end
    end

    // Next state
    always_comb begin
        hold_full_d   = hold_full_q && !issue;
        hold_type_d   = hold_type_q;
        hold_bank_d   = hold_bank_q;
        issue_valid_d = issue;
        issue_type_d  = issue_type_q;
        issue_bank_d  = issue_bank_q;
        trrd_cnt_d    = dec_sat(trrd_cnt_q);
        tccd_cnt_d    = dec_sat(tccd_cnt_q);
        twtr_cnt_d    = dec_sat(twtr_cnt_q);
        for (int i = 0; i < 4; i++) begin
            faw_d[i] = dec_sat(faw_q[i]);
        end

        // NOP and reserved types are consumed without occupying the register.
        if (accept && keep_type) begin
            hold_full_d = 1'b1;
            hold_type_d = cmd_type;
            hold_bank_d = cmd_bank;
        end

        if (issue) begin
            issue_type_d = hold_type_q;
            issue_bank_d = hold_bank_q;
            if (hold_type_q == CMD_ACT) begin
                trrd_cnt_d     = LOAD_TRRD;
                faw_d[faw_idx] = LOAD_TFAW;
            end
            if ((hold_type_q == CMD_RD) || (hold_type_q == CMD_WR)) begin
                tccd_cnt_d = LOAD_TCCD;
            end
            if (hold_type_q == CMD_WR) begin
                twtr_cnt_d = LOAD_TWTR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full_q   <= 1'b0;
            hold_type_q   <= '0;
            hold_bank_q   <= '0;
            issue_valid_q <= 1'b0;
            issue_type_q  <= '0;
            issue_bank_q  <= '0;
            trrd_cnt_q    <= '0;
            tccd_cnt_q    <= '0;
            twtr_cnt_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                faw_q[i] <= '0;
            end
        end else begin
            hold_full_q   <= hold_full_d;
            hold_type_q   <= hold_type_d;
            hold_bank_q   <= hold_bank_d;
            issue_valid_q <= issue_valid_d;
            issue_type_q  <= issue_type_d;
            issue_bank_q  <= issue_bank_d;
            trrd_cnt_q    <= trrd_cnt_d;
            tccd_cnt_q    <= tccd_cnt_d;
            twtr_cnt_q    <= twtr_cnt_d;
            for (int i = 0; i < 4; i++) begin
                faw_q[i] <= faw_d[i];
            end
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_type  = issue_type_q;
    assign issue_bank  = issue_bank_q;

endmodule
